// File: rtl/debug_baud_ctrl.sv
// Debug auto-baud sequencer: validates the detector divisor, owns the live divisor and baud tick,
// and retrains on framing errors. Optional LOCKED idle timeout under `DEBUG_BAUD_TIMEOUT_EN.
module debug_baud_ctrl #(
  parameter logic [7:0] DEF_DIV   = 8'd26,
  parameter logic [7:0] MIN_DIV   = 8'd2,
  parameter logic [3:0] ERR_LIMIT = 4'd4
`ifdef DEBUG_BAUD_TIMEOUT_EN
  , parameter int unsigned TO_BITS = 16
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ab_wr,
  input  logic [7:0] ab_div,
  output logic       ab_clr,
  input  logic       frame_err,
  input  logic       rx_ok,
  input  logic       cfg_wr,
  input  logic [7:0] cfg_div,
  output logic [7:0] baud_div,
  output logic       baud_tick,
  output logic       baud_valid,
  output logic [1:0] state,
  output logic [3:0] err_cnt
);

  typedef enum logic [1:0] {
    S_RESTART = 2'd0,
    S_DETECT  = 2'd1,
    S_LOCKED  = 2'd2,
    S_MANUAL  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [7:0] tick_cnt_q, tick_cnt_d;
  logic [3:0] err_q, err_d;
  logic [3:0] err_inc;
  logic       valid;
  logic       tick;

  assign valid   = (state_q == S_LOCKED) || (state_q == S_MANUAL);
  assign tick    = valid && (tick_cnt_q == div_q);
  assign err_inc = (err_q == 4'hf) ? err_q : err_q + 4'd1;

`ifdef DEBUG_BAUD_TIMEOUT_EN
  logic [TO_BITS-1:0] to_cnt_q, to_cnt_d;
  logic               to_expired;

  assign to_expired = &to_cnt_q;
`endif

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    err_d      = err_q;
    tick_cnt_d = tick ? 8'd0 : tick_cnt_q + 8'd1;

    case (state_q)
      S_RESTART: state_d = S_DETECT;
      S_DETECT: begin
        if (ab_wr) begin
          if (ab_div >= MIN_DIV) begin
            div_d      = ab_div;
            err_d      = 4'd0;
            tick_cnt_d = 8'd0;
            state_d    = S_LOCKED;
          end else begin
            state_d = S_RESTART;
          end
        end
      end
      S_LOCKED: begin
        if (frame_err) begin
          if (err_inc == ERR_LIMIT) begin
            err_d   = 4'd0;
            state_d = S_RESTART;
          end else begin
            err_d = err_inc;
          end
        end else if (rx_ok) begin
          err_d = 4'd0;
        end
`ifdef DEBUG_BAUD_TIMEOUT_EN
        // A silent line may mean the host switched baud rate.
        if (to_expired) state_d = S_RESTART;
`endif
      end
      S_MANUAL: begin
        if (frame_err)  err_d = err_inc;
        else if (rx_ok) err_d = 4'd0;
      end
      default: state_d = S_RESTART;
    endcase

    // Host writes beat everything else in the same cycle.
    if (cfg_wr) begin
      if (cfg_div != 8'd0) begin
        div_d      = cfg_div;
        tick_cnt_d = 8'd0;
        err_d      = 4'd0;
        state_d    = S_MANUAL;
      end else begin
        state_d = S_RESTART;
      end
    end

    if (!((state_d == S_LOCKED) || (state_d == S_MANUAL))) tick_cnt_d = 8'd0;
  end

`ifdef DEBUG_BAUD_TIMEOUT_EN
  always_comb begin
    to_cnt_d = to_cnt_q;
    if ((state_q != S_LOCKED) || (state_d != S_LOCKED) || rx_ok) to_cnt_d = '0;
    else if (tick)                                                to_cnt_d = to_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RESTART;
      div_q      <= DEF_DIV;
      tick_cnt_q <= 8'd0;
      err_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      err_q      <= err_d;
    end
  end

  assign ab_clr     = (state_q == S_RESTART);
  assign baud_div   = div_q;
  assign baud_tick  = tick;
  assign baud_valid = valid;
  assign state      = state_q;
  assign err_cnt    = err_q;

endmodule
